scie_issue_ctrl: RTL and testbench

SCIE_ISSUE_CTRL -- requirements
Module: scie_issue_ctrl

---
 rtl/scie_pkg.sv | 19 +
 rtl/scie_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_scie_issue_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scie_pkg.sv
// Shared defaults and FSM state encoding for the SCIE issue controller.
package scie_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int TAG_W_DEF    = 5;
    localparam int PIPE_LAT_DEF = 2;
    // Wide enough for the largest legal pipeline latency (15).
    localparam int CNT_W        = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DISPATCH  = 3'd1,
        PIPE_WAIT = 3'd2,
        MC_REQ    = 3'd3,
        MC_WAIT   = 3'd4,
        RESP      = 3'd5
    } state_e;

endpackage

// File: rtl/scie_issue_ctrl.sv
// Single-outstanding issue controller: latches one core request, drives the external SCIE
// decoder/datapath, collects the unpipelined, pipelined or multicycle result and writes it back.
module scie_issue_ctrl
    import scie_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_insn,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,

    output logic [31:0]      scie_insn,
    output logic [XLEN-1:0]  scie_rs1,
    output logic [XLEN-1:0]  scie_rs2,
    input  logic             scie_unpipelined,
    input  logic             scie_pipelined,
    input  logic             scie_multicycle,
    output logic             scie_valid,
    input  logic [XLEN-1:0]  scie_rd_comb,
    input  logic [XLEN-1:0]  scie_rd_pipe,

    output logic             mc_req_valid,
    input  logic             mc_req_ready,
    input  logic             mc_resp_valid,
    input  logic [XLEN-1:0]  mc_resp_data,

    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_illegal,

    output logic             busy
);

    state_e             state_q, state_d;
    logic [31:0]        insn_q, insn_d;
    logic [XLEN-1:0]    rs1_q, rs1_d;
    logic [XLEN-1:0]    rs2_q, rs2_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            insn_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            insn_q    <= insn_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        insn_d       = insn_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        tag_d        = tag_q;
        result_d     = result_q;
        illegal_d    = illegal_q;
        cnt_d        = cnt_q;
        req_ready    = (state_q == IDLE) && !reset;
        scie_valid   = 1'b0;
        mc_req_valid = 1'b0;
        wb_valid     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    insn_d    = req_insn;
                    rs1_d     = req_rs1;
                    rs2_d     = req_rs2;
                    tag_d     = req_tag;
                    result_d  = '0;
                    illegal_d = 1'b0;
                    state_d   = DISPATCH;
                end
            end
            DISPATCH: begin
                // Class priority: unpipelined, then pipelined, then multicycle.
                if (scie_unpipelined) begin
                    result_d = scie_rd_comb;
                    state_d  = RESP;
                end else if (scie_pipelined) begin
                    scie_valid = 1'b1;
                    cnt_d      = CNT_W'(PIPE_LAT - 1);
                    state_d    = PIPE_WAIT;
                end else if (scie_multicycle) begin
                    state_d = MC_REQ;
                end else begin
                    result_d  = '0;
                    illegal_d = 1'b1;
                    state_d   = RESP;
                end
            end
            PIPE_WAIT: begin
                // Counter reaches zero in the cycle PIPE_LAT after the issue strobe.
                if (cnt_q == '0) begin
                    result_d = scie_rd_pipe;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MC_REQ: begin
                mc_req_valid = 1'b1;
                if (mc_req_ready) begin
                    state_d = MC_WAIT;
                end
            end
            MC_WAIT: begin
                if (mc_resp_valid) begin
                    result_d = mc_resp_data;
                    state_d  = RESP;
                end
            end
            RESP: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign scie_insn  = insn_q;
    assign scie_rs1   = rs1_q;
    assign scie_rs2   = rs2_q;
    assign wb_tag     = tag_q;
    assign wb_data    = result_q;
    assign wb_illegal = illegal_q && (state_q == RESP);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_scie_issue_ctrl.sv
// Directed bench for scie_issue_ctrl with a behavioural SCIE decoder/datapath and a writeback scoreboard.
module tb_scie_issue_ctrl;

    localparam int XLEN     = 32;
    localparam int TAG_W    = 5;
    localparam int PIPE_LAT = 2;

    logic             clock;
    logic             reset;
    logic             req_valid, req_ready;
    logic [31:0]      req_insn;
    logic [XLEN-1:0]  req_rs1, req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      scie_insn;
    logic [XLEN-1:0]  scie_rs1, scie_rs2;
    logic             scie_unpipelined, scie_pipelined, scie_multicycle;
    logic             scie_valid;
    logic [XLEN-1:0]  scie_rd_comb, scie_rd_pipe;
    logic             mc_req_valid, mc_req_ready, mc_resp_valid;
    logic [XLEN-1:0]  mc_resp_data;
    logic             wb_valid, wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [XLEN-1:0]  wb_data;
    logic             wb_illegal;
    logic             busy;

    scie_issue_ctrl #(
        .XLEN     (XLEN),
        .TAG_W    (TAG_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_insn         (req_insn),
        .req_rs1          (req_rs1),
        .req_rs2          (req_rs2),
        .req_tag          (req_tag),
        .scie_insn        (scie_insn),
        .scie_rs1         (scie_rs1),
        .scie_rs2         (scie_rs2),
        .scie_unpipelined (scie_unpipelined),
        .scie_pipelined   (scie_pipelined),
        .scie_multicycle  (scie_multicycle),
        .scie_valid       (scie_valid),
        .scie_rd_comb     (scie_rd_comb),
        .scie_rd_pipe     (scie_rd_pipe),
        .mc_req_valid     (mc_req_valid),
        .mc_req_ready     (mc_req_ready),
        .mc_resp_valid    (mc_resp_valid),
        .mc_resp_data     (mc_resp_data),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_tag           (wb_tag),
        .wb_data          (wb_data),
        .wb_illegal       (wb_illegal),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Decoder model: insn[0]=unpipelined, insn[1]=pipelined, insn[2]=multicycle.
    assign scie_unpipelined = scie_insn[0];
    assign scie_pipelined   = scie_insn[1];
    assign scie_multicycle  = scie_insn[2];
    assign scie_rd_comb     = scie_rs1 + scie_rs2;

    // Two-stage pipe: the result is only correct exactly PIPE_LAT cycles after the strobe.
    logic [XLEN-1:0] pipe0 = 32'hBAD0BAD0;
    logic [XLEN-1:0] pipe1 = 32'hBAD0BAD0;
    always @(posedge clock) begin
        pipe0 <= scie_valid ? (scie_rs1 ^ scie_rs2) : 32'hBAD0BAD0;
        pipe1 <= pipe0;
    end
    assign scie_rd_pipe = pipe1;

    int cyc   = 0;
    int n_sv  = 0;
    int n_mc  = 0;
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (scie_valid === 1'b1) n_sv <= n_sv + 1;
        if (mc_req_valid === 1'b1 && mc_req_ready === 1'b1) n_mc <= n_mc + 1;
    end

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
        logic             ill;
        logic [31:0]      insn;
        int               lat;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int p0    = 0;
    int sv0   = 0;
    int mc0   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request (called at a negedge in IDLE); returns at the first DISPATCH negedge.
    task automatic issue(input logic [31:0] insn, input logic [XLEN-1:0] rs1,
                         input logic [XLEN-1:0] rs2, input logic [TAG_W-1:0] tag,
                         input logic [XLEN-1:0] exp_data, input logic exp_ill,
                         input int exp_lat, input bit push);
        exp_t e;
        chk("issue_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_tag   = tag;
        @(negedge clock);
        req_valid = 1'b0;
        req_insn  = 32'h0;
        req_rs1   = '0;
        req_rs2   = '0;
        req_tag   = '0;
        p0 = cyc;
        chk("dispatch_busy", 64'(busy), 64'd1);
        chk("dispatch_req_ready", 64'(req_ready), 64'd0);
        chk("dispatch_rs1", 64'(scie_rs1), 64'(rs1));
        if (push) begin
            e.tag  = tag;
            e.data = exp_data;
            e.ill  = exp_ill;
            e.insn = insn;
            e.lat  = exp_lat;
            sb.push_back(e);
        end
    endtask

    // Waits (bounded) for wb_valid, holds wb_ready low for 'hold' cycles, then handshakes.
    task automatic wait_wb(input int hold);
        exp_t e;
        int lat;
        lat = cyc - p0 + 1;
        while (wb_valid !== 1'b1 && lat < 200) begin
            @(negedge clock);
            lat = cyc - p0 + 1;
        end
        chk("wb_seen", 64'(wb_valid), 64'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        chk("wb_latency", 64'(lat), 64'(e.lat));
        for (int i = 0; i < hold; i++) begin
            chk("bp_wb_valid", 64'(wb_valid), 64'd1);
            chk("bp_wb_illegal", 64'(wb_illegal), 64'(e.ill));
            chk("bp_wb_data", 64'(wb_data), 64'(e.data));
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            @(negedge clock);
        end
        chk("wb_tag", 64'(wb_tag), 64'(e.tag));
        chk("wb_data", 64'(wb_data), 64'(e.data));
        chk("wb_illegal", 64'(wb_illegal), 64'(e.ill));
        chk("wb_scie_insn_stable", 64'(scie_insn), 64'(e.insn));
        wb_ready = 1'b1;
        @(negedge clock);
        wb_ready = 1'b0;
        chk("post_wb_valid", 64'(wb_valid), 64'd0);
        chk("post_wb_busy", 64'(busy), 64'd0);
        chk("post_wb_req_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_insn      = 32'h0;
        req_rs1       = '0;
        req_rs2       = '0;
        req_tag       = '0;
        mc_req_ready  = 1'b0;
        mc_resp_valid = 1'b0;
        mc_resp_data  = '0;
        wb_ready      = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_scie_valid", 64'(scie_valid), 64'd0);
        chk("rst_mc_req_valid", 64'(mc_req_valid), 64'd0);
        chk("rst_wb_illegal", 64'(wb_illegal), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_scie_insn", 64'(scie_insn), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Unpipelined: 5+7 with tag 3.
        sv0 = n_sv;
        issue(32'h1, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 2, 1'b1);
        chk("up_scie_valid", 64'(scie_valid), 64'd0);
        wait_wb(0);
        chk("up_sv_count", 64'(n_sv - sv0), 64'd0);

        // Pipelined: 0x10 ^ 0x20.
        sv0 = n_sv;
        issue(32'h2, 32'h10, 32'h20, 5'd7, 32'h30, 1'b0, 2 + PIPE_LAT, 1'b1);
        chk("pp_scie_valid_t1", 64'(scie_valid), 64'd1);
        @(negedge clock);
        chk("pp_scie_valid_t2", 64'(scie_valid), 64'd0);
        wait_wb(0);
        chk("pp_sv_count", 64'(n_sv - sv0), 64'd1);

        // Priority: all classes -> unpipelined; pipelined+multicycle -> pipelined.
        sv0 = n_sv;
        issue(32'h7, 32'd100, 32'd23, 5'd9, 32'd123, 1'b0, 2, 1'b1);
        wait_wb(0);
        chk("prio_up_sv_count", 64'(n_sv - sv0), 64'd0);
        mc0 = n_mc;
        issue(32'h6, 32'hF0F0_0000, 32'h0F0F_1234, 5'd12, 32'hFFFF_1234, 1'b0, 2 + PIPE_LAT, 1'b1);
        wait_wb(0);
        chk("prio_pp_mc_count", 64'(n_mc - mc0), 64'd0);

        // Multicycle: request stalled 3 cycles, stray response during MC_REQ, real response 5 cycles later.
        mc0 = n_mc;
        issue(32'h4, 32'd1, 32'd2, 5'd21, 32'hDEADBEEF, 1'b0, 11, 1'b1);
        chk("mc_dispatch_req_valid", 64'(mc_req_valid), 64'd0);
        @(negedge clock);
        chk("mc_req_valid_0", 64'(mc_req_valid), 64'd1);
        mc_resp_valid = 1'b1;
        mc_resp_data  = 32'h1111_1111;
        @(negedge clock);
        mc_resp_valid = 1'b0;
        mc_resp_data  = '0;
        chk("mc_req_valid_1", 64'(mc_req_valid), 64'd1);
        @(negedge clock);
        chk("mc_req_valid_2", 64'(mc_req_valid), 64'd1);
        @(negedge clock);
        mc_req_ready = 1'b1;
        @(negedge clock);
        mc_req_ready = 1'b0;
        chk("mc_wait_req_valid", 64'(mc_req_valid), 64'd0);
        chk("mc_wait_wb_valid", 64'(wb_valid), 64'd0);
        repeat (4) @(negedge clock);
        chk("mc_wait_busy", 64'(busy), 64'd1);
        chk("mc_wait_no_wb", 64'(wb_valid), 64'd0);
        mc_resp_valid = 1'b1;
        mc_resp_data  = 32'hDEADBEEF;
        @(negedge clock);
        mc_resp_valid = 1'b0;
        mc_resp_data  = '0;
        wait_wb(0);
        chk("mc_handshakes", 64'(n_mc - mc0), 64'd1);

        // Illegal with four cycles of writeback back-pressure.
        issue(32'h0, 32'd9, 32'd9, 5'd17, 32'd0, 1'b1, 2, 1'b1);
        wait_wb(4);

        // Reset while in MC_WAIT, then a stray late response.
        issue(32'h4, 32'hAB, 32'hCD, 5'd5, 32'd0, 1'b0, 0, 1'b0);
        mc_req_ready = 1'b1;
        @(negedge clock);
        chk("rmc_req_valid", 64'(mc_req_valid), 64'd1);
        @(negedge clock);
        mc_req_ready = 1'b0;
        chk("rmc_in_wait", 64'(mc_req_valid), 64'd0);
        chk("rmc_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("rmc_rst_busy", 64'(busy), 64'd0);
        chk("rmc_rst_req_ready", 64'(req_ready), 64'd0);
        chk("rmc_rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rmc_rst_scie_insn", 64'(scie_insn), 64'd0);
        reset         = 1'b0;
        mc_resp_valid = 1'b1;
        mc_resp_data  = 32'hCAFE_F00D;
        @(negedge clock);
        mc_resp_valid = 1'b0;
        mc_resp_data  = '0;
        chk("rmc_after_req_ready", 64'(req_ready), 64'd1);
        chk("rmc_after_busy", 64'(busy), 64'd0);
        chk("rmc_after_wb_valid", 64'(wb_valid), 64'd0);
        @(negedge clock);
        chk("rmc_late_wb_valid", 64'(wb_valid), 64'd0);
        chk("rmc_late_busy", 64'(busy), 64'd0);

        // Recovery after reset: unpipelined with wraparound and maximum tag.
        issue(32'h1, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'd0, 1'b0, 2, 1'b1);
        wait_wb(0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
